// File: rtl/multicycle_controlunit.sv
// Multi-cycle LEGv8 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on memory
// handshakes, stretches MUL, and traps illegal opcodes and memory timeouts.
module multicycle_controlunit #(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNTW        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     opcode,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            imem_req,
    output logic            ir_write,
    output logic            pc_inc,
    output logic            ubranch,
    output logic            branch,
    output logic            reg2loc,
    output logic            alu_src,
    output logic [2:0]      alu_op,
    output logic            shift_dir,
    output logic            flag_write,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            instr_retired,
    output logic [CNTW-1:0] retire_count,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_FAULT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_ADDI, C_ADDS, C_B, C_BLT, C_CBZ, C_LDUR,
        C_LSL, C_LSR, C_MUL, C_STUR, C_SUBS
    } cls_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [15:0] MUL_LAST  = 16'(MUL_CYCLES - 1);

    function automatic cls_t decode(input logic [10:0] op);
        casez (op)
            11'b1001000100?: return C_ADDI;
            11'b10101011000: return C_ADDS;
            11'b000101?????: return C_B;
            11'b01010100???: return C_BLT;
            11'b10110100???: return C_CBZ;
            11'b11111000010: return C_LDUR;
            11'b11010011011: return C_LSL;
            11'b11010011010: return C_LSR;
            11'b10011011000: return C_MUL;
            11'b11111000000: return C_STUR;
            11'b11101011000: return C_SUBS;
            default:         return C_ILLEGAL;
        endcase
    endfunction

    state_t          st, nxt;
    cls_t            cls, dec_cls, ncls;
    logic [15:0]     wait_cnt, mul_cnt;
    logic            retire;
    logic [CNTW-1:0] count_q;
    logic            imem_req_q, branch_q, reg2loc_q, alu_src_q, shift_dir_q, flag_write_q;
    logic            dmem_read_q, dmem_write_q, mem_to_reg_q, reg_write_q, fault_q;
    logic [2:0]      alu_op_q;
    logic [1:0]      fault_code_q;
    logic            ex_reg2loc, ex_alu_src, ex_shift_dir, ex_flag_write, ex_branch;
    logic [2:0]      ex_alu_op;

    // Next-state and retirement; the class comes straight from the opcode while in DECODE.
    always_comb begin
        nxt     = st;
        retire  = 1'b0;
        dec_cls = decode(opcode);
        ncls    = (st == S_DECODE) ? dec_cls : cls;
        case (st)
            S_FETCH: begin
                if (imem_ready)                nxt = S_DECODE;
                else if (wait_cnt == WAIT_LAST) nxt = S_FAULT;
            end
            S_DECODE: begin
                if (dec_cls == C_ILLEGAL) nxt = S_FAULT;
                else if (dec_cls == C_B) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end else nxt = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_CBZ, C_BLT: begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end
                    C_LDUR, C_STUR: nxt = S_MEM;
                    C_MUL: if (mul_cnt == MUL_LAST) nxt = S_WB;
                    default: nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (cls == C_LDUR) nxt = S_WB;
                    else begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end
                end else if (wait_cnt == WAIT_LAST) nxt = S_FAULT;
            end
            S_WB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default: nxt = S_FAULT;
        endcase
    end

    // EXEC control word for the instruction about to execute.
    always_comb begin
        ex_reg2loc    = (ncls == C_CBZ) || (ncls == C_STUR);
        ex_alu_src    = (ncls == C_ADDI) || (ncls == C_LDUR) || (ncls == C_STUR) ||
                        (ncls == C_LSL) || (ncls == C_LSR);
        ex_shift_dir  = (ncls == C_LSR);
        ex_flag_write = (ncls == C_ADDS) || (ncls == C_SUBS);
        ex_branch     = (ncls == C_CBZ) || (ncls == C_BLT);
        case (ncls)
            C_SUBS:         ex_alu_op = 3'b011;
            C_LSL, C_LSR:   ex_alu_op = 3'b001;
            C_MUL:          ex_alu_op = 3'b111;
            C_CBZ, C_BLT:   ex_alu_op = 3'b000;
            default:        ex_alu_op = 3'b010;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= S_FETCH;
            cls          <= C_ILLEGAL;
            wait_cnt     <= '0;
            mul_cnt      <= '0;
            count_q      <= '0;
            imem_req_q   <= 1'b1;
            branch_q     <= 1'b0;
            reg2loc_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= 3'b000;
            shift_dir_q  <= 1'b0;
            flag_write_q <= 1'b0;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            st       <= nxt;
            count_q  <= count_q + CNTW'(retire);
            wait_cnt <= (nxt == st && (st == S_FETCH || st == S_MEM)) ? wait_cnt + 16'd1 : '0;
            mul_cnt  <= (st == S_EXEC && nxt == S_EXEC) ? mul_cnt + 16'd1 : '0;
            if (st == S_DECODE) cls <= dec_cls;
            // Registered controls reflect the state being entered, so they are stable all cycle.
            imem_req_q   <= (nxt == S_FETCH);
            branch_q     <= (nxt == S_EXEC) && ex_branch;
            reg2loc_q    <= (nxt == S_EXEC) && ex_reg2loc;
            alu_src_q    <= (nxt == S_EXEC) && ex_alu_src;
            alu_op_q     <= (nxt == S_EXEC) ? ex_alu_op : 3'b000;
            shift_dir_q  <= (nxt == S_EXEC) && ex_shift_dir;
            flag_write_q <= (nxt == S_EXEC) && ex_flag_write;
            dmem_read_q  <= (nxt == S_MEM) && (ncls == C_LDUR);
            dmem_write_q <= (nxt == S_MEM) && (ncls == C_STUR);
            mem_to_reg_q <= (nxt == S_WB) && (ncls == C_LDUR);
            reg_write_q  <= (nxt == S_WB);
            if (nxt == S_FAULT && st != S_FAULT) begin
                fault_q      <= 1'b1;
                fault_code_q <= (st == S_DECODE) ? 2'b01 : 2'b10;
            end
        end
    end

    // Reset masks every output so an aborted instruction issues nothing on the reset cycle.
    assign imem_req      = imem_req_q & ~reset;
    assign ir_write      = ~reset & (st == S_FETCH) & imem_ready;
    assign pc_inc        = ~reset & (st == S_FETCH) & imem_ready;
    assign ubranch       = ~reset & (st == S_DECODE) & (dec_cls == C_B);
    assign branch        = branch_q & ~reset;
    assign reg2loc       = reg2loc_q & ~reset;
    assign alu_src       = alu_src_q & ~reset;
    assign alu_op        = reset ? 3'b000 : alu_op_q;
    assign shift_dir     = shift_dir_q & ~reset;
    assign flag_write    = flag_write_q & ~reset;
    assign dmem_read     = dmem_read_q & ~reset;
    assign dmem_write    = dmem_write_q & ~reset;
    assign mem_to_reg    = mem_to_reg_q & ~reset;
    assign reg_write     = reg_write_q & ~reset;
    assign instr_retired = retire & ~reset;
    assign retire_count  = reset ? '0 : count_q;
    assign fault         = fault_q & ~reset;
    assign fault_code    = reset ? 2'b00 : fault_code_q;
    assign state         = reset ? 3'd0 : 3'(st);

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Bench for multicycle_controlunit: a per-instruction trace model expands each instruction
// into expected per-cycle inputs/outputs, then one loop replays and compares every cycle.
module tb_multicycle_controlunit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_write, pc_inc, ubranch, branch, reg2loc, alu_src;
    logic [2:0]  alu_op;
    logic        shift_dir, flag_write, dmem_read, dmem_write, mem_to_reg, reg_write;
    logic        instr_retired, fault;
    logic [3:0]  retire_count;
    logic [1:0]  fault_code;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_write, pc_inc, ubranch, branch, reg2loc, alu_src;
        logic [2:0] alu_op;
        logic       shift_dir, flag_write, dmem_read, dmem_write, mem_to_reg, reg_write;
        logic       retired;
        logic [3:0] cnt;
        logic       fault;
        logic [1:0] fcode;
    } outs_t;

    typedef struct {
        logic        rst, ir, dr;
        logic [10:0] op;
        outs_t       exp;
        int          pst, pcnt, pfc;
    } rec_t;

    typedef enum {K_ILL, K_ADDI, K_ADDS, K_B, K_BLT, K_CBZ, K_LDUR,
                  K_LSL, K_LSR, K_MUL, K_STUR, K_SUBS} kind_t;

    localparam logic [10:0] OP_ADDI = 11'b10010001000, OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_B    = 11'b00010100110, OP_BLT  = 11'b01010100011;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101, OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_LSL  = 11'b11010011011, OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_MUL  = 11'b10011011000, OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000, OP_ILL  = 11'h000;

    rec_t       q[$];
    int         mcount = 0;
    logic [1:0] mfcode = 2'b00;
    int         checks = 0;
    int         failures = 0;
    outs_t      act;

    multicycle_controlunit #(.MUL_CYCLES(4), .MEM_TIMEOUT(16), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc), .ubranch(ubranch),
        .branch(branch), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
        .shift_dir(shift_dir), .flag_write(flag_write), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .instr_retired(instr_retired), .retire_count(retire_count),
        .fault(fault), .fault_code(fault_code), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {state, imem_req, ir_write, pc_inc, ubranch, branch, reg2loc, alu_src,
                  alu_op, shift_dir, flag_write, dmem_read, dmem_write, mem_to_reg,
                  reg_write, instr_retired, retire_count, fault, fault_code};

    function automatic kind_t kind_of(input logic [10:0] op);
        if (op ==? 11'b1001000100?) return K_ADDI;
        if (op ==? 11'b10101011000) return K_ADDS;
        if (op ==? 11'b000101?????) return K_B;
        if (op ==? 11'b01010100???) return K_BLT;
        if (op ==? 11'b10110100???) return K_CBZ;
        if (op ==? 11'b11111000010) return K_LDUR;
        if (op ==? 11'b11010011011) return K_LSL;
        if (op ==? 11'b11010011010) return K_LSR;
        if (op ==? 11'b10011011000) return K_MUL;
        if (op ==? 11'b11111000000) return K_STUR;
        if (op ==? 11'b11101011000) return K_SUBS;
        return K_ILL;
    endfunction

    function automatic outs_t base(input logic [2:0] s);
        outs_t o = '0;
        o.st  = s;
        o.cnt = 4'(mcount);
        if (s == 3'd5) begin
            o.fault = 1'b1;
            o.fcode = mfcode;
        end
        return o;
    endfunction

    task automatic push(input logic rst, input logic ir, input logic dr,
                        input logic [10:0] op, input outs_t e);
        rec_t r;
        r.rst = rst; r.ir = ir; r.dr = dr; r.op = op; r.exp = e;
        r.pst = -1; r.pcnt = -1; r.pfc = -1;
        q.push_back(r);
    endtask

    task automatic pin_at(input int idx, input int pst, input int pcnt, input int pfc);
        q[idx].pst  = pst;
        q[idx].pcnt = pcnt;
        q[idx].pfc  = pfc;
    endtask

    task automatic add_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b1, OP_ADDI, outs_t'('0));
        mcount = 0;
        mfcode = 2'b00;
    endtask

    task automatic add_fault(input int n, input logic [10:0] op);
        for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b1, op, base(3'd5));
    endtask

    task automatic add_fetch_timeout();
        outs_t o;
        for (int i = 0; i < 16; i++) begin
            o = base(3'd0);
            o.imem_req = 1'b1;
            push(1'b0, 1'b0, 1'b1, OP_ADDS, o);
        end
        mfcode = 2'b10;
    endtask

    // Expands one instruction into its cycle trace; ready inputs stay high wherever they should be ignored.
    task automatic add_instr(input logic [10:0] op, input int iwait, input int dwait, input bit abort_mem);
        outs_t o;
        kind_t k = kind_of(op);
        for (int i = 0; i < iwait; i++) begin
            o = base(3'd0); o.imem_req = 1'b1;
            push(1'b0, 1'b0, 1'b1, op, o);
        end
        o = base(3'd0); o.imem_req = 1'b1; o.ir_write = 1'b1; o.pc_inc = 1'b1;
        push(1'b0, 1'b1, 1'b1, op, o);
        o = base(3'd1);
        if (k == K_ILL) begin
            push(1'b0, 1'b1, 1'b1, op, o);
            mfcode = 2'b01;
            return;
        end
        if (k == K_B) begin
            o.ubranch = 1'b1; o.retired = 1'b1;
            push(1'b0, 1'b1, 1'b1, op, o);
            mcount = (mcount + 1) % 16;
            return;
        end
        push(1'b0, 1'b1, 1'b1, op, o);
        for (int i = 0; i < ((k == K_MUL) ? 4 : 1); i++) begin
            o = base(3'd2);
            o.reg2loc    = k inside {K_CBZ, K_STUR};
            o.alu_src    = k inside {K_ADDI, K_LDUR, K_STUR, K_LSL, K_LSR};
            o.shift_dir  = (k == K_LSR);
            o.flag_write = k inside {K_ADDS, K_SUBS};
            o.branch     = k inside {K_CBZ, K_BLT};
            o.alu_op     = (k == K_SUBS) ? 3'b011 : (k inside {K_LSL, K_LSR}) ? 3'b001 :
                           (k == K_MUL) ? 3'b111 : (k inside {K_CBZ, K_BLT}) ? 3'b000 : 3'b010;
            o.retired    = o.branch;
            push(1'b0, 1'b1, 1'b1, op, o);
        end
        if (k inside {K_CBZ, K_BLT}) begin
            mcount = (mcount + 1) % 16;
            return;
        end
        if (k inside {K_LDUR, K_STUR}) begin
            o = base(3'd3);
            o.dmem_read = (k == K_LDUR); o.dmem_write = (k == K_STUR);
            for (int i = 0; i < dwait; i++) push(1'b0, 1'b1, 1'b0, op, o);
            if (abort_mem) begin
                add_reset(1);
                return;
            end
            if (k == K_STUR) begin
                o.retired = 1'b1;
                push(1'b0, 1'b1, 1'b1, op, o);
                mcount = (mcount + 1) % 16;
                return;
            end
            push(1'b0, 1'b1, 1'b1, op, o);
        end
        o = base(3'd4);
        o.reg_write = 1'b1; o.mem_to_reg = (k == K_LDUR); o.retired = 1'b1;
        push(1'b0, 1'b1, 1'b1, op, o);
        mcount = (mcount + 1) % 16;
    endtask

    task automatic add_idle();
        outs_t o = base(3'd0);
        o.imem_req = 1'b1;
        push(1'b0, 1'b0, 1'b1, OP_ADDI, o);
    endtask

    task automatic applyStimulus(input int i);
        reset      = q[i].rst;
        imem_ready = q[i].ir;
        dmem_ready = q[i].dr;
        opcode     = q[i].op;
    endtask

    task automatic checkOutput(input int i);
        checks++;
        if (act !== q[i].exp) begin
            failures++;
            $display("[TB] FAIL cycle%0d outputs got=%h expected=%h", i, act, q[i].exp);
        end
        if (q[i].pst >= 0) begin
            checks++;
            if (int'(state) != q[i].pst) begin
                failures++;
                $display("[TB] FAIL cycle%0d state got=%0d expected=%0d", i, state, q[i].pst);
            end
        end
        if (q[i].pcnt >= 0) begin
            checks++;
            if (int'(retire_count) != q[i].pcnt) begin
                failures++;
                $display("[TB] FAIL cycle%0d retire_count got=%0d expected=%0d", i, retire_count, q[i].pcnt);
            end
        end
        if (q[i].pfc >= 0) begin
            checks++;
            if (int'(fault_code) != q[i].pfc) begin
                failures++;
                $display("[TB] FAIL cycle%0d fault_code got=%0d expected=%0d", i, fault_code, q[i].pfc);
            end
        end
    endtask

    initial begin
        int s;
        add_reset(2);
        pin_at(0, 0, 0, 0);
        s = q.size(); add_instr(OP_ADDI, 0, 0, 0);
        pin_at(s + 1, 1, 0, -1); pin_at(s + 2, 2, 0, -1); pin_at(s + 3, 4, 0, -1);
        s = q.size(); add_instr(OP_LDUR, 0, 3, 0);
        pin_at(s, 0, 1, -1); pin_at(s + 3, 3, -1, -1); pin_at(s + 6, 3, -1, -1); pin_at(s + 7, 4, 1, -1);
        s = q.size(); add_instr(OP_MUL, 0, 0, 0);
        pin_at(s + 5, 2, -1, -1); pin_at(s + 6, 4, 2, -1);
        add_instr(OP_CBZ, 1, 0, 0);
        add_instr(OP_BLT, 0, 0, 0);
        add_instr(OP_STUR, 2, 1, 0);
        add_instr(OP_LSL, 0, 0, 0);
        add_instr(OP_LSR, 0, 0, 0);
        add_instr(OP_SUBS, 0, 0, 0);
        add_instr(OP_B, 0, 0, 0);
        s = q.size(); add_instr(OP_ILL, 0, 0, 0);
        add_fault(4, OP_ILL);
        pin_at(s + 2, 5, 10, 1); pin_at(s + 5, 5, -1, 1);
        add_reset(1);
        s = q.size(); add_fetch_timeout();
        add_fault(3, OP_ADDS);
        pin_at(s + 15, 0, -1, 0); pin_at(s + 16, 5, 0, 2);
        add_reset(1);
        add_instr(OP_ADDS, 0, 0, 0);
        s = q.size(); add_reset(1);
        pin_at(s, 0, 0, 0);
        s = q.size();
        for (int i = 0; i < 16; i++) add_instr(OP_B, 0, 0, 0);
        pin_at(s + 30, 0, 15, -1);
        add_instr(OP_STUR, 0, 2, 1);
        pin_at(s + 32, 0, 0, -1);
        add_instr(OP_ADDI, 0, 0, 0);
        s = q.size(); add_idle();
        pin_at(s, 0, 1, 0);

        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(i);
            @(negedge clk);
            checkOutput(i);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
